// File: rtl/buffered_router.sv
// Routes din to one of NUM_PORTS per-channel FIFOs; head word visible one cycle after accept.
// din_ready drops when the addressed FIFO is full; BUFFERED_ROUTER_DROP_EN instead drops and counts.
module buffered_router #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PORTS  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [DATA_WIDTH-1:0]                       din,
    input  logic                                        din_valid,
    input  logic [$clog2(NUM_PORTS)-1:0]                din_addr,
    output logic                                        din_ready,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]             dout,
    output logic [NUM_PORTS-1:0]                        dout_valid,
    input  logic [NUM_PORTS-1:0]                        dout_ready,
    output logic [NUM_PORTS*($clog2(FIFO_DEPTH)+1)-1:0] occupancy
`ifdef BUFFERED_ROUTER_DROP_EN
    ,
    output logic [15:0]                                 drop_cnt
`endif
);

    localparam int AW = $clog2(NUM_PORTS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int OW = PW + 1;

    logic [NUM_PORTS-1:0] w_full;
    logic                 w_dest_full;
    logic                 w_push_en;

    // Fullness is judged before any same-cycle pop, so a full FIFO never takes a word.
    assign w_dest_full = w_full[din_addr];

`ifdef BUFFERED_ROUTER_DROP_EN
    logic        w_drop;
    logic [15:0] r_drop_cnt;

    assign din_ready = 1'b1;
    assign w_push_en = din_valid && !w_dest_full;
    assign w_drop    = din_valid && w_dest_full;
    assign drop_cnt  = r_drop_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end
`else
    assign din_ready = !w_dest_full;
    assign w_push_en = din_valid && din_ready;
`endif

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_ch
        logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
        logic [PW-1:0]         r_wptr;
        logic [PW-1:0]         r_rptr;
        logic [OW-1:0]         r_cnt;
        logic                  w_push;
        logic                  w_pop;
        logic                  w_empty;

        assign w_empty   = (r_cnt == '0);
        assign w_full[k] = (r_cnt == OW'(FIFO_DEPTH));
        assign w_push    = w_push_en && (din_addr == AW'(k));
        assign w_pop     = !w_empty && dout_ready[k];

        // Storage is deliberately left unreset; the empty mask on dout hides stale words.
        always_ff @(posedge clk) begin
            if (w_push && !reset) begin
                r_mem[r_wptr] <= din;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_cnt  <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + PW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PW'(1);
                end
                if (w_push && !w_pop) begin
                    r_cnt <= r_cnt + OW'(1);
                end else if (w_pop && !w_push) begin
                    r_cnt <= r_cnt - OW'(1);
                end
            end
        end

        assign dout_valid[k]                    = !w_empty;
        assign dout[k*DATA_WIDTH +: DATA_WIDTH] = w_empty ? '0 : r_mem[r_rptr];
        assign occupancy[k*OW +: OW]            = r_cnt;
    end

endmodule

// File: tb/tb_buffered_router.sv
// Checks buffered_router (4 ports, depth 4) with a directed vector table and a queue-based random model.
module tb_buffered_router;

    localparam int NP = 4;
    localparam int FD = 4;
    localparam int OW = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  din;
    logic         din_valid;
    logic [1:0]   din_addr;
    logic         din_ready;
    logic [127:0] dout;
    logic [3:0]   dout_valid;
    logic [3:0]   dout_ready;
    logic [11:0]  occupancy;
`ifdef BUFFERED_ROUTER_DROP_EN
    logic [15:0]  drop_cnt;
`endif

    buffered_router #(.DATA_WIDTH(32), .NUM_PORTS(NP), .FIFO_DEPTH(FD)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_addr   (din_addr),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .occupancy  (occupancy)
`ifdef BUFFERED_ROUTER_DROP_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [1:0] a,
                         input logic [31:0] d, input logic [3:0] rd);
        reset      = r;
        din_valid  = v;
        din_addr   = a;
        din        = d;
        dout_ready = rd;
    endtask

`ifndef BUFFERED_ROUTER_DROP_EN
    typedef struct {
        logic         rst;
        logic         vld;
        logic [1:0]   addr;
        logic [31:0]  din;
        logic [3:0]   rdy;
        logic         exp_rdy;
        logic [3:0]   exp_vld;
        logic [11:0]  exp_occ;
        logic [127:0] exp_dout;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [11:0] occ4(int c0, int c1, int c2, int c3);
        return {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
    endfunction

    function automatic logic [127:0] dat4(logic [31:0] d0, logic [31:0] d1,
                                          logic [31:0] d2, logic [31:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    function automatic vec_t mk(logic r, logic v, logic [1:0] a, logic [31:0] d, logic [3:0] rd,
                                logic er, logic [3:0] ev, logic [11:0] eo, logic [127:0] ed);
        vec_t t;
        t.rst = r; t.vld = v; t.addr = a; t.din = d; t.rdy = rd;
        t.exp_rdy = er; t.exp_vld = ev; t.exp_occ = eo; t.exp_dout = ed;
        return t;
    endfunction
`endif

    logic [31:0] mq [NP][$];
    int          mdrop;

    initial begin
`ifndef BUFFERED_ROUTER_DROP_EN
        // Basic routing, then expiry of the word.
        tbl.push_back(mk(0, 1, 2, 32'hA5A5_0001, 4'hF, 1, 4'b0100, occ4(0,0,1,0), dat4(0,0,32'hA5A5_0001,0)));
        tbl.push_back(mk(0, 0, 2, 0, 4'hF, 1, 4'b0000, occ4(0,0,0,0), dat4(0,0,0,0)));
        // Fill channel 1 with 1..5 stalled; the fifth is refused, then drain in order.
        tbl.push_back(mk(0, 1, 1, 1, 4'h0, 1, 4'b0010, occ4(0,1,0,0), dat4(0,1,0,0)));
        tbl.push_back(mk(0, 1, 1, 2, 4'h0, 1, 4'b0010, occ4(0,2,0,0), dat4(0,1,0,0)));
        tbl.push_back(mk(0, 1, 1, 3, 4'h0, 1, 4'b0010, occ4(0,3,0,0), dat4(0,1,0,0)));
        tbl.push_back(mk(0, 1, 1, 4, 4'h0, 1, 4'b0010, occ4(0,4,0,0), dat4(0,1,0,0)));
        tbl.push_back(mk(0, 1, 1, 5, 4'h0, 0, 4'b0010, occ4(0,4,0,0), dat4(0,1,0,0)));
        tbl.push_back(mk(0, 0, 1, 0, 4'b0010, 0, 4'b0010, occ4(0,3,0,0), dat4(0,2,0,0)));
        tbl.push_back(mk(0, 0, 1, 0, 4'b0010, 1, 4'b0010, occ4(0,2,0,0), dat4(0,3,0,0)));
        tbl.push_back(mk(0, 0, 1, 0, 4'b0010, 1, 4'b0010, occ4(0,1,0,0), dat4(0,4,0,0)));
        tbl.push_back(mk(0, 0, 1, 0, 4'b0010, 1, 4'b0000, occ4(0,0,0,0), dat4(0,0,0,0)));
        // Full channel 0: pop and push together -> pop only.
        tbl.push_back(mk(0, 1, 0, 32'h10, 4'h0, 1, 4'b0001, occ4(1,0,0,0), dat4(32'h10,0,0,0)));
        tbl.push_back(mk(0, 1, 0, 32'h11, 4'h0, 1, 4'b0001, occ4(2,0,0,0), dat4(32'h10,0,0,0)));
        tbl.push_back(mk(0, 1, 0, 32'h12, 4'h0, 1, 4'b0001, occ4(3,0,0,0), dat4(32'h10,0,0,0)));
        tbl.push_back(mk(0, 1, 0, 32'h13, 4'h0, 1, 4'b0001, occ4(4,0,0,0), dat4(32'h10,0,0,0)));
        tbl.push_back(mk(0, 1, 0, 32'h14, 4'b0001, 0, 4'b0001, occ4(3,0,0,0), dat4(32'h11,0,0,0)));
        tbl.push_back(mk(0, 0, 0, 0, 4'h0, 1, 4'b0001, occ4(3,0,0,0), dat4(32'h11,0,0,0)));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0001, 1, 4'b0001, occ4(2,0,0,0), dat4(32'h12,0,0,0)));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0001, 1, 4'b0001, occ4(1,0,0,0), dat4(32'h13,0,0,0)));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0001, 1, 4'b0000, occ4(0,0,0,0), dat4(0,0,0,0)));
        // Channel 3 full and stalled must not block channel 0.
        tbl.push_back(mk(0, 1, 3, 32'h20, 4'h0, 1, 4'b1000, occ4(0,0,0,1), dat4(0,0,0,32'h20)));
        tbl.push_back(mk(0, 1, 3, 32'h21, 4'h0, 1, 4'b1000, occ4(0,0,0,2), dat4(0,0,0,32'h20)));
        tbl.push_back(mk(0, 1, 3, 32'h22, 4'h0, 1, 4'b1000, occ4(0,0,0,3), dat4(0,0,0,32'h20)));
        tbl.push_back(mk(0, 1, 3, 32'h23, 4'h0, 1, 4'b1000, occ4(0,0,0,4), dat4(0,0,0,32'h20)));
        tbl.push_back(mk(0, 1, 3, 32'h24, 4'h0, 0, 4'b1000, occ4(0,0,0,4), dat4(0,0,0,32'h20)));
        tbl.push_back(mk(0, 1, 0, 32'hBB, 4'h0, 1, 4'b1001, occ4(1,0,0,4), dat4(32'hBB,0,0,32'h20)));
        // Load channels 0 and 1 to two words each, then reset beats a concurrent push/pop.
        tbl.push_back(mk(0, 1, 0, 32'hCC, 4'h0, 1, 4'b1001, occ4(2,0,0,4), dat4(32'hBB,0,0,32'h20)));
        tbl.push_back(mk(0, 1, 1, 32'hD1, 4'h0, 1, 4'b1011, occ4(2,1,0,4), dat4(32'hBB,32'hD1,0,32'h20)));
        tbl.push_back(mk(0, 1, 1, 32'hD2, 4'h0, 1, 4'b1011, occ4(2,2,0,4), dat4(32'hBB,32'hD1,0,32'h20)));
        tbl.push_back(mk(1, 1, 1, 32'hEE, 4'hF, 1, 4'b0000, occ4(0,0,0,0), dat4(0,0,0,0)));
        tbl.push_back(mk(0, 0, 0, 0, 4'h0, 1, 4'b0000, occ4(0,0,0,0), dat4(0,0,0,0)));
`endif

        drive(1, 0, 0, 0, 4'h0);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 4'hF);
        #2;
        chk("rst_vld", 128'(dout_valid), 128'h0);
        chk("rst_dout", dout, 128'h0);
        chk("rst_occ", 128'(occupancy), 128'h0);
        chk("rst_rdy", 128'(din_ready), 128'h1);

`ifndef BUFFERED_ROUTER_DROP_EN
        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            drive(tbl[i].rst, tbl[i].vld, tbl[i].addr, tbl[i].din, tbl[i].rdy);
            #2;
            chk($sformatf("tbl%0d_rdy", i), 128'(din_ready), 128'(tbl[i].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_vld", i), 128'(dout_valid), 128'(tbl[i].exp_vld));
            chk($sformatf("tbl%0d_occ", i), 128'(occupancy), 128'(tbl[i].exp_occ));
            chk($sformatf("tbl%0d_dout", i), dout, tbl[i].exp_dout);
            drive(0, 0, 0, 0, 4'h0);
        end
`else
        // Channel 2 full and stalled: three more words are dropped and counted.
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            drive(0, 1, 2, 32'h200 + 32'(i), 4'h0);
            #2;
            chk($sformatf("drop_rdy%0d", i), 128'(din_ready), 128'h1);
        end
        @(posedge clk);
        #1;
        drive(0, 0, 2, 0, 4'h0);
        #2;
        chk("drop_cnt", 128'(drop_cnt), 128'd3);
        chk("drop_occ", 128'(occupancy[2*OW +: OW]), 128'd4);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            drive(0, 0, 2, 0, 4'b0100);
            #2;
            chk($sformatf("drop_head%0d", i), 128'(dout[64 +: 32]), 128'(32'h200 + 32'(i)));
        end
        @(posedge clk);
        #1;
        drive(0, 0, 2, 0, 4'h0);
        #2;
        chk("drop_empty", 128'(dout_valid), 128'h0);
`endif

        // Random traffic against per-channel queues.
        @(posedge clk);
        #1;
        drive(1, 0, 0, 0, 4'h0);
        @(posedge clk);
        for (int k = 0; k < NP; k++) mq[k].delete();
        mdrop = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic       r;
            logic       v;
            logic [1:0] a;
            logic [3:0] rd;
            bit         exp_rdy;
            #1;
            r  = ($urandom_range(0, 99) == 0);
            v  = ($urandom_range(0, 3) != 0);
            a  = 2'($urandom);
            rd = ((cyc % 400) < 200) ? 4'($urandom & $urandom) : 4'($urandom | $urandom);
            drive(r, v, a, $urandom, rd);
            #2;
`ifdef BUFFERED_ROUTER_DROP_EN
            exp_rdy = 1'b1;
            chk("rnd_drop", 128'(drop_cnt), 128'(mdrop));
`else
            exp_rdy = (mq[a].size() < FD);
`endif
            chk("rnd_rdy", 128'(din_ready), 128'(exp_rdy));
            for (int k = 0; k < NP; k++) begin
                chk($sformatf("rnd_vld%0d", k), 128'(dout_valid[k]), 128'(mq[k].size() != 0));
                chk($sformatf("rnd_dout%0d", k), 128'(dout[k*32 +: 32]),
                    128'((mq[k].size() != 0) ? mq[k][0] : 32'h0));
                chk($sformatf("rnd_occ%0d", k), 128'(occupancy[k*OW +: OW]), 128'(mq[k].size()));
            end
            @(posedge clk);
            if (r) begin
                for (int k = 0; k < NP; k++) mq[k].delete();
                mdrop = 0;
            end else begin
                bit full_before;
                full_before = (mq[a].size() >= FD);
                for (int k = 0; k < NP; k++) begin
                    if (rd[k] && mq[k].size() != 0) void'(mq[k].pop_front());
                end
                if (v && !full_before) mq[a].push_back(din);
                if (v && full_before && mdrop < 16'hFFFF) mdrop++;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/buffered_router.md
BUFFERED_ROUTER -- requirements
Module: buffered_router

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of every data word.
REQ-002 Parameter NUM_PORTS, default 4, SHALL set the number of output channels; legal values are powers of two, 2..16.
REQ-003 Parameter FIFO_DEPTH, default 4, SHALL set the per-output buffer depth in words; legal values are powers of two, 2..64.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-006 din  input  DATA_WIDTH  SHALL be the input data word.
REQ-007 din_valid  input  1  SHALL indicate that din and din_addr are valid.
REQ-008 din_addr  input  $clog2(NUM_PORTS)  SHALL select the destination output channel.
REQ-009 din_ready  output  1  SHALL indicate that the block accepts the current input word.
REQ-010 dout  output  NUM_PORTS*DATA_WIDTH  SHALL carry the output words, channel k in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 dout_valid  output  NUM_PORTS  SHALL flag per channel that its dout slice holds a valid word.
REQ-012 dout_ready  input  NUM_PORTS  SHALL flag per channel that the sink consumes the word.
REQ-013 occupancy  output  NUM_PORTS*($clog2(FIFO_DEPTH)+1)  SHALL report each channel's FIFO word count.

Function
REQ-014 Each channel SHALL own one FIFO of FIFO_DEPTH words, with binary read/write pointers that wrap from FIFO_DEPTH-1 to 0.
REQ-015 An input transfer SHALL occur in a cycle where din_valid=1 and din_ready=1; the word is written into FIFO[din_addr].
REQ-016 din_ready SHALL be combinational: 1 when FIFO[din_addr] is not full, independent of din_valid.
REQ-017 A full FIFO SHALL NOT accept a word even if its head is popped in the same cycle.
REQ-018 An output transfer on channel k SHALL occur when dout_valid[k]=1 and dout_ready[k]=1, and it SHALL pop the head word.
REQ-019 dout_valid[k] SHALL equal "FIFO[k] not empty"; the dout slice SHALL show the head word, and all-zeros when the FIFO is empty.
REQ-020 Latency SHALL be one cycle: a word accepted at edge N appears on dout with dout_valid=1 after edge N.
REQ-021 On an empty FIFO, push and pop SHALL NOT happen in the same cycle, because dout_valid=0 blocks the pop.
REQ-022 Simultaneous push and pop on a non-empty, non-full FIFO SHALL leave its occupancy unchanged and keep word order.
REQ-023 Words to the same channel SHALL leave in arrival order; channels SHALL be independent, so a stalled channel never blocks traffic to the others.
REQ-024 occupancy[k] SHALL range 0..FIFO_DEPTH, change by +1 on push, -1 on pop, and 0 on both.

Reset
REQ-025 When reset=1 at a clock edge, all pointers and occupancies SHALL go to 0, all FIFOs become empty, and dout_valid=0 and dout=0 from the next cycle.
REQ-026 Reset SHALL take priority over a push or pop in the same cycle; words held mid-operation are discarded.
REQ-027 FIFO storage contents need not be reset; they SHALL never be visible on dout while the FIFO is empty.

Configuration
REQ-028 With macro BUFFERED_ROUTER_DROP_EN defined, din_ready SHALL be tied to 1 and a valid word addressed to a full FIFO SHALL be discarded.
REQ-029 With BUFFERED_ROUTER_DROP_EN defined, a 16-bit output port drop_cnt SHALL exist, reset to 0, increment once per discarded word, and saturate at 16'hFFFF.
REQ-030 Without BUFFERED_ROUTER_DROP_EN, drop_cnt SHALL be absent and backpressure SHALL follow REQ-016/017.

Verification
REQ-031 Basic routing: after reset, drive din=32'hA5A5_0001, addr=2, valid for 1 cycle, with dout_ready=4'b1111 -> next cycle dout_valid=4'b0100, channel 2 slice=32'hA5A5_0001; following cycle dout_valid=0.
REQ-032 Fill and backpressure: dout_ready=0, push 5 words 1..5 to channel 1 -> din_ready drops to 0 after 4 accepts and occupancy[1]=4; release dout_ready[1] -> words 1,2,3,4 exit in order.
REQ-033 Full-boundary rule: with channel 0 full, assert din_valid to addr 0 and dout_ready[0] in the same cycle -> pop occurs, push rejected, occupancy becomes 3, and din_ready=1 next cycle.
REQ-034 Independence: channel 3 full and stalled, push 32'h0000_00BB to channel 0 -> accepted, with dout_valid[0]=1 next cycle.
REQ-035 Reset mid-operation: with channels 0 and 1 holding 2 words each, pulse reset for 1 cycle -> dout_valid=0, dout=0, occupancy all 0, din_ready=1.
REQ-036 Drop mode (macro defined): channel 2 full and stalled, push 3 words to addr 2 -> din_ready stays 1, drop_cnt=3, and channel 2 contents are unchanged.
